// File: rtl/ipm2l_sync_pkt_fifo_if.sv
// Write/read bundle of ipm2l_sync_pkt_fifo: the framer/consumer side uses the master modport,
// the FIFO itself uses the slave modport.
interface ipm2l_sync_pkt_fifo_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 9
);
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   wr_en;
  logic                   wr_commit;
  logic                   wr_discard;
  logic                   wr_full;
  logic                   almost_full;
  logic [DEPTH_WIDTH:0]   wr_water_level;
  logic                   overflow;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   rd_en;
  logic                   rd_empty;
  logic                   rd_valid;
  logic                   almost_empty;
  logic [DEPTH_WIDTH:0]   rd_water_level;
  logic                   underflow;

  modport master (
    output wr_data, wr_en, wr_commit, wr_discard, rd_en,
    input  wr_full, almost_full, wr_water_level, overflow,
           rd_data, rd_empty, rd_valid, almost_empty, rd_water_level, underflow
  );

  modport slave (
    input  wr_data, wr_en, wr_commit, wr_discard, rd_en,
    output wr_full, almost_full, wr_water_level, overflow,
           rd_data, rd_empty, rd_valid, almost_empty, rd_water_level, underflow
  );
endinterface

// File: rtl/ipm2l_sync_pkt_fifo.sv
// Single-clock packet FIFO: words become visible to the reader only once committed, and an
// uncommitted packet can be rolled back. Optional first-word-fall-through output stage.
module ipm2l_sync_pkt_fifo #(
  parameter int DATA_WIDTH       = 32,
  parameter int DEPTH_WIDTH      = 9,
  parameter int FWFT             = 1,
  parameter int PKT_MODE         = 1,
  parameter int ALMOST_FULL_NUM  = 508,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ipm2l_sync_pkt_fifo_if.slave bus
);

  localparam int              PW        = DEPTH_WIDTH + 1;
  localparam int              RAM_WORDS = 1 << DEPTH_WIDTH;
  localparam logic [PW-1:0]   CAPACITY  = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [PW-1:0]   PTR_ZERO  = {PW{1'b0}};
  localparam logic [31:0]     AF_THRESH = ALMOST_FULL_NUM;
  localparam logic [31:0]     AE_THRESH = ALMOST_EMPTY_NUM;
  localparam logic            FWFT_EN   = (FWFT != 0);
  localparam logic            PKT_EN    = (PKT_MODE != 0);

  logic [DATA_WIDTH-1:0] mem_q [0:RAM_WORDS-1];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         cm_ptr_q, cm_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q;
  logic                  underflow_q;

  logic [PW-1:0]         wr_ptr_inc_s;
  logic [PW-1:0]         wr_level_s;
  logic [PW-1:0]         ram_level_s;
  logic [PW-1:0]         rd_level_s;
  logic                  wr_full_s;
  logic                  ram_empty_s;
  logic                  rd_empty_s;
  logic                  wr_accept_s;
  logic                  ram_we_s;
  logic                  rd_pop_s;
  logic                  ram_rd_s;
  logic                  out_word_s;

  // Flags come from registered pointers only; the writer sees speculative words, the reader does not.
  assign wr_level_s  = wr_ptr_q - rd_ptr_q;
  assign ram_level_s = cm_ptr_q - rd_ptr_q;
  assign wr_full_s   = (wr_level_s == CAPACITY);
  assign ram_empty_s = (ram_level_s == PTR_ZERO);
  assign rd_empty_s  = FWFT_EN ? ~rd_valid_q : ram_empty_s;
  assign out_word_s  = FWFT_EN & rd_valid_q;
  assign rd_level_s  = ram_level_s + {{DEPTH_WIDTH{1'b0}}, out_word_s};

  assign wr_accept_s = bus.wr_en & ~wr_full_s;
  assign ram_we_s    = wr_accept_s & ~(PKT_EN & bus.wr_discard);
  assign rd_pop_s    = bus.rd_en & ~rd_empty_s;

  // Write/commit pointer next state; discard overrides commit and drops the same-cycle write.
  always_comb begin
    wr_ptr_inc_s = wr_ptr_q + {{DEPTH_WIDTH{1'b0}}, wr_accept_s};
    wr_ptr_d     = wr_ptr_inc_s;
    cm_ptr_d     = cm_ptr_q;
    if (!PKT_EN) begin
      cm_ptr_d = wr_ptr_inc_s;
    end else if (bus.wr_discard) begin
      wr_ptr_d = cm_ptr_q;
    end else if (bus.wr_commit) begin
      cm_ptr_d = wr_ptr_inc_s;
    end else begin
      cm_ptr_d = cm_ptr_q;
    end
  end

  // Read side: FWFT refills the output register whenever it is empty or being popped.
  always_comb begin
    ram_rd_s   = 1'b0;
    rd_valid_d = 1'b0;
    if (FWFT_EN) begin
      ram_rd_s   = ~ram_empty_s & (~rd_valid_q | rd_pop_s);
      rd_valid_d = ram_rd_s | (rd_valid_q & ~rd_pop_s);
    end else begin
      ram_rd_s   = rd_pop_s;
      rd_valid_d = rd_pop_s;
    end
    rd_ptr_d = rd_ptr_q + {{DEPTH_WIDTH{1'b0}}, ram_rd_s};
    if (ram_rd_s) begin
      rd_data_d = mem_q[rd_ptr_q[DEPTH_WIDTH-1:0]];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Storage array, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]] <= bus.wr_data;
    end else begin
      mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]] <= mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]];
    end
  end

  // Pointer, output-stage and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= PTR_ZERO;
      cm_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      rd_data_q   <= {DATA_WIDTH{1'b0}};
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      cm_ptr_q    <= cm_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= bus.wr_en & wr_full_s;
      underflow_q <= bus.rd_en & rd_empty_s;
    end
  end

  assign bus.wr_full        = wr_full_s;
  assign bus.almost_full    = (32'(wr_level_s) >= AF_THRESH);
  assign bus.wr_water_level = wr_level_s;
  assign bus.overflow       = overflow_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_empty       = rd_empty_s;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.almost_empty   = (32'(rd_level_s) <= AE_THRESH);
  assign bus.rd_water_level = rd_level_s;
  assign bus.underflow      = underflow_q;

endmodule

// File: tb/tb_ipm2l_sync_pkt_fifo.sv
// Directed bench for ipm2l_sync_pkt_fifo: three 16-deep instances (stream FWFT, packet FWFT,
// packet standard-read) share one stimulus; each phase checks the instance it targets.
module tb_ipm2l_sync_pkt_fifo;

  logic       clk;
  logic       rst_n;
  logic       drv_we;
  logic [7:0] drv_wd;
  logic       drv_cm;
  logic       drv_dc;
  logic       drv_re;

  int n_chk;
  int n_fail;

  ipm2l_sync_pkt_fifo_if #(.DATA_WIDTH(8), .DEPTH_WIDTH(4)) if_a ();
  ipm2l_sync_pkt_fifo_if #(.DATA_WIDTH(8), .DEPTH_WIDTH(4)) if_b ();
  ipm2l_sync_pkt_fifo_if #(.DATA_WIDTH(8), .DEPTH_WIDTH(4)) if_s ();

  assign if_a.wr_en = drv_we;  assign if_a.wr_data = drv_wd;  assign if_a.wr_commit = drv_cm;
  assign if_a.wr_discard = drv_dc;  assign if_a.rd_en = drv_re;
  assign if_b.wr_en = drv_we;  assign if_b.wr_data = drv_wd;  assign if_b.wr_commit = drv_cm;
  assign if_b.wr_discard = drv_dc;  assign if_b.rd_en = drv_re;
  assign if_s.wr_en = drv_we;  assign if_s.wr_data = drv_wd;  assign if_s.wr_commit = drv_cm;
  assign if_s.wr_discard = drv_dc;  assign if_s.rd_en = drv_re;

  ipm2l_sync_pkt_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .FWFT(1), .PKT_MODE(0),
    .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  ipm2l_sync_pkt_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .FWFT(1), .PKT_MODE(1),
    .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  ipm2l_sync_pkt_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .FWFT(0), .PKT_MODE(1),
    .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)) dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       cm;
    logic       dc;
    logic       re;
    int         ewl;
    int         erl;
    logic       emp;
    logic       und;
    logic       chkd;
    logic [7:0] edat;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic cm, dc, re,
                              input int ewl, erl, input logic emp, und, chkd,
                              input logic [7:0] edat);
    vec_t v;
    v.we = we; v.wd = wd; v.cm = cm; v.dc = dc; v.re = re;
    v.ewl = ewl; v.erl = erl; v.emp = emp; v.und = und; v.chkd = chkd; v.edat = edat;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    drv_we = 1'b0; drv_wd = 8'h00; drv_cm = 1'b0; drv_dc = 1'b0; drv_re = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_rst(input string tag, input logic wf, af, input logic [4:0] wl,
                         input logic ov, input logic [7:0] rd, input logic emp, rv, ae,
                         input logic [4:0] rl, input logic un);
    chk({tag, "_wr_full"}, 0, wf, 1'b0);
    chk({tag, "_almost_full"}, 0, af, 1'b0);
    chk({tag, "_wr_lvl"}, 0, wl, 5'd0);
    chk({tag, "_overflow"}, 0, ov, 1'b0);
    chk({tag, "_rd_data"}, 0, rd, 8'h00);
    chk({tag, "_rd_empty"}, 0, emp, 1'b1);
    chk({tag, "_rd_valid"}, 0, rv, 1'b0);
    chk({tag, "_almost_empty"}, 0, ae, 1'b1);
    chk({tag, "_rd_lvl"}, 0, rl, 5'd0);
    chk({tag, "_underflow"}, 0, un, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] qc[$];
    logic [7:0] qp[$];
    logic [7:0] exp_d;
    logic       m_full, m_empty, m_rd, m_acc;
    int         lvl;
    int         n_reads;

    n_chk = 0; n_fail = 0; n_reads = 0;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk_rst("RST_B", if_b.wr_full, if_b.almost_full, if_b.wr_water_level, if_b.overflow,
            if_b.rd_data, if_b.rd_empty, if_b.rd_valid, if_b.almost_empty,
            if_b.rd_water_level, if_b.underflow);
    chk_rst("RST_S", if_s.wr_full, if_s.almost_full, if_s.wr_water_level, if_s.overflow,
            if_s.rd_data, if_s.rd_empty, if_s.rd_valid, if_s.almost_empty,
            if_s.rd_water_level, if_s.underflow);
    do_reset();

    // Stream mode, FWFT: 16 RAM words plus the output register hold 17 words.
    for (int i = 0; i < 17; i++) begin
      drv_we = 1'b1; drv_wd = 8'(i);
      tick();
      lvl = (i == 0) ? 1 : i;  // word 0 moves to the output register one edge after it lands
      chk("A_wr_full", i, if_a.wr_full, (i == 16));
      chk("A_wr_lvl", i, if_a.wr_water_level, lvl);
      chk("A_almost_full", i, if_a.almost_full, (i >= 14));
    end
    drv_wd = 8'hEE;
    tick();
    chk("A_overflow", 0, if_a.overflow, 1'b1);
    chk("A_wr_lvl_ovf", 0, if_a.wr_water_level, 16);
    drv_we = 1'b0;
    tick();
    chk("A_overflow_clr", 0, if_a.overflow, 1'b0);
    for (int k = 0; k < 17; k++) begin
      chk("A_rd_data", k, if_a.rd_data, k);
      chk("A_rd_empty", k, if_a.rd_empty, 1'b0);
      chk("A_rd_lvl", k, if_a.rd_water_level, 17 - k);
      chk("A_almost_empty", k, if_a.almost_empty, ((17 - k) <= 2));
      drv_re = 1'b1;
      tick();
      if (k == 0) chk("A_wr_full_rel", k, if_a.wr_full, 1'b0);
    end
    chk("A_empty_end", 0, if_a.rd_empty, 1'b1);
    tick();
    chk("A_underflow", 0, if_a.underflow, 1'b1);
    drv_re = 1'b0;

    // Packet mode, FWFT: commit, discard, commit+discard, empty commit.
    do_reset();
    tbl[0]  = mk(1, 8'h10, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00);
    tbl[1]  = mk(1, 8'h11, 0, 0, 0, 2, 0, 1, 0, 0, 8'h00);
    tbl[2]  = mk(1, 8'h12, 0, 0, 0, 3, 0, 1, 0, 0, 8'h00);
    tbl[3]  = mk(1, 8'h13, 0, 0, 0, 4, 0, 1, 0, 0, 8'h00);
    tbl[4]  = mk(1, 8'h14, 0, 0, 0, 5, 0, 1, 0, 0, 8'h00);
    tbl[5]  = mk(1, 8'h15, 1, 0, 0, 6, 6, 1, 0, 0, 8'h00);
    tbl[6]  = mk(0, 8'h00, 0, 0, 0, 5, 6, 0, 0, 1, 8'h10);
    tbl[7]  = mk(0, 8'h00, 0, 0, 1, 4, 5, 0, 0, 1, 8'h11);
    tbl[8]  = mk(0, 8'h00, 0, 0, 1, 3, 4, 0, 0, 1, 8'h12);
    tbl[9]  = mk(0, 8'h00, 0, 0, 1, 2, 3, 0, 0, 1, 8'h13);
    tbl[10] = mk(0, 8'h00, 0, 0, 1, 1, 2, 0, 0, 1, 8'h14);
    tbl[11] = mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 1, 8'h15);
    tbl[12] = mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00);
    tbl[13] = mk(1, 8'h20, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00);
    tbl[14] = mk(1, 8'h21, 0, 0, 0, 2, 0, 1, 0, 0, 8'h00);
    tbl[15] = mk(1, 8'h22, 0, 0, 0, 3, 0, 1, 0, 0, 8'h00);
    tbl[16] = mk(1, 8'h23, 0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    tbl[17] = mk(1, 8'hA0, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00);
    tbl[18] = mk(1, 8'hA1, 1, 0, 0, 2, 2, 1, 0, 0, 8'h00);
    tbl[19] = mk(0, 8'h00, 0, 0, 0, 1, 2, 0, 0, 1, 8'hA0);
    tbl[20] = mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 1, 8'hA1);
    tbl[21] = mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00);
    tbl[22] = mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 0, 8'h00);
    tbl[23] = mk(1, 8'h30, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00);
    tbl[24] = mk(1, 8'h31, 0, 0, 0, 2, 0, 1, 0, 0, 8'h00);
    tbl[25] = mk(1, 8'h32, 0, 0, 0, 3, 0, 1, 0, 0, 8'h00);
    tbl[26] = mk(1, 8'h33, 0, 0, 0, 4, 0, 1, 0, 0, 8'h00);
    tbl[27] = mk(0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    tbl[28] = mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    tbl[29] = mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    tbl[30] = mk(1, 8'h40, 1, 0, 0, 1, 1, 1, 0, 0, 8'h00);
    tbl[31] = mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 1, 8'h40);
    for (int v = 0; v < 32; v++) begin
      drv_we = tbl[v].we; drv_wd = tbl[v].wd; drv_cm = tbl[v].cm;
      drv_dc = tbl[v].dc; drv_re = tbl[v].re;
      tick();
      chk("B_wr_lvl", v, if_b.wr_water_level, tbl[v].ewl);
      chk("B_rd_lvl", v, if_b.rd_water_level, tbl[v].erl);
      chk("B_rd_empty", v, if_b.rd_empty, tbl[v].emp);
      chk("B_underflow", v, if_b.underflow, tbl[v].und);
      if (tbl[v].chkd) chk("B_rd_data", v, if_b.rd_data, tbl[v].edat);
    end
    idle_inputs();

    // Standard read: rd_valid pulses one edge after each accepted rd_en.
    do_reset();
    drv_we = 1'b1; drv_wd = 8'h40;
    tick();
    chk("C_uncommitted_empty", 0, if_s.rd_empty, 1'b1);
    drv_wd = 8'h41; drv_cm = 1'b1;
    tick();
    idle_inputs();
    chk("C_commit_empty", 0, if_s.rd_empty, 1'b0);
    chk("C_commit_lvl", 0, if_s.rd_water_level, 2);
    drv_re = 1'b1;
    tick();
    chk("C_valid", 0, if_s.rd_valid, 1'b1);
    chk("C_data", 0, if_s.rd_data, 8'h40);
    tick();
    chk("C_valid", 1, if_s.rd_valid, 1'b1);
    chk("C_data", 1, if_s.rd_data, 8'h41);
    drv_re = 1'b0;
    tick();
    chk("C_valid_off", 0, if_s.rd_valid, 1'b0);
    chk("C_data_hold", 0, if_s.rd_data, 8'h41);
    chk("C_empty_end", 0, if_s.rd_empty, 1'b1);

    // Random traffic against a committed/pending queue model.
    for (int n = 0; n < 1000; n++) begin
      drv_we = ($urandom_range(0, 99) < 60);
      drv_wd = 8'($urandom);
      drv_cm = ($urandom_range(0, 99) < 20);
      drv_dc = ($urandom_range(0, 99) < 4);
      drv_re = ($urandom_range(0, 99) < 50);
      m_full  = ((qc.size() + qp.size()) == 16);
      m_empty = (qc.size() == 0);
      m_rd    = drv_re && !m_empty;
      m_acc   = drv_we && !m_full;
      exp_d   = 8'h00;
      if (m_rd) begin
        exp_d = qc.pop_front();
        n_reads++;
      end
      if (drv_dc) begin
        qp.delete();
      end else begin
        if (m_acc) qp.push_back(drv_wd);
        if (drv_cm) while (qp.size() > 0) qc.push_back(qp.pop_front());
      end
      tick();
      chk("R_rd_valid", n, if_s.rd_valid, m_rd);
      if (m_rd) chk("R_rd_data", n, if_s.rd_data, exp_d);
      chk("R_wr_lvl", n, if_s.wr_water_level, qc.size() + qp.size());
      chk("R_rd_lvl", n, if_s.rd_water_level, qc.size());
      chk("R_overflow", n, if_s.overflow, drv_we && m_full);
      chk("R_underflow", n, if_s.underflow, drv_re && m_empty);
    end
    idle_inputs();
    chk("R_wrap_reads", 0, (n_reads >= 96), 1'b1);

    // Asynchronous reset in the middle of a packet.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drv_we = 1'b1; drv_wd = 8'(8'h50 + i); drv_cm = (i == 9);
      tick();
    end
    idle_inputs();
    chk("D_pre_b_rd_lvl", 0, if_b.rd_water_level, 10);
    chk("D_pre_b_wr_lvl", 0, if_b.wr_water_level, 12);
    chk("D_pre_s_rd_lvl", 0, if_s.rd_water_level, 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk_rst("D_B", if_b.wr_full, if_b.almost_full, if_b.wr_water_level, if_b.overflow,
            if_b.rd_data, if_b.rd_empty, if_b.rd_valid, if_b.almost_empty,
            if_b.rd_water_level, if_b.underflow);
    chk_rst("D_S", if_s.wr_full, if_s.almost_full, if_s.wr_water_level, if_s.overflow,
            if_s.rd_data, if_s.rd_empty, if_s.rd_valid, if_s.almost_empty,
            if_s.rd_water_level, if_s.underflow);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drv_we = 1'b1; drv_wd = 8'h77; drv_cm = 1'b1;
    tick();
    idle_inputs();
    chk("D_s_empty", 0, if_s.rd_empty, 1'b0);
    chk("D_s_rd_lvl", 0, if_s.rd_water_level, 1);
    tick();
    chk("D_b_data", 0, if_b.rd_data, 8'h77);
    chk("D_b_empty", 0, if_b.rd_empty, 1'b0);
    chk("D_b_rd_lvl", 0, if_b.rd_water_level, 1);
    drv_re = 1'b1;
    tick();
    drv_re = 1'b0;
    chk("D_b_empty_after", 0, if_b.rd_empty, 1'b1);
    chk("D_s_valid", 0, if_s.rd_valid, 1'b1);
    chk("D_s_data", 0, if_s.rd_data, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
